dbus_arbiter: RTL

- Shares the single downstream data-memory generic bus between two requesters.
- Port 0 is the pipeline memory stage; port 1 is a secondary master (debug/prefetch/page-walk).
- Registered grant FSM with fixed-priority or round-robin selection, plus a starvation counter for port 1 in fixed mode.
- Non-granted requesters see busy=1 and stall exactly as on a slow cache.

---
 rtl/dbus_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares one downstream data-memory bus between two masters.
//   Port 0 is the pipeline memory stage, port 1 a secondary master. Arbitration
//   is registered (one IDLE cycle before every grant). In fixed-priority mode
//   port 0 wins ties unless port 1 has lost MAX_WAIT arbitrations in a row; in
//   round-robin mode a tie goes to the port that was not granted last.
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   mK_ren/wen/addr/wdata/byte_en  request from master K (K = 0, 1)
//   mK_rdata, mK_busy   response to master K; busy=1 means stall
//   s_*                 downstream bus (s_busy low = transfer complete)
//   grant               one-hot current grant (00 in IDLE)
//   abort_err           pulse: granted master dropped its request mid-transfer
module dbus_arbiter #(
    parameter int unsigned RR_MODE  = 0,
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                m0_ren,
    input  logic                m0_wen,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_byte_en,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_busy,
    input  logic                m1_ren,
    input  logic                m1_wen,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_byte_en,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_busy,
    output logic                s_ren,
    output logic                s_wen,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_byte_en,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_busy,
    output logic [1:0]          grant,
    output logic                abort_err
);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    localparam logic [7:0] MaxWait = MAX_WAIT[7:0];

    state_e     state_q, state_d;
    logic       last_gnt_q, last_gnt_d;   // 1 = port 1 completed last
    logic [7:0] wait_cnt_q, wait_cnt_d;   // consecutive arbitrations lost by port 1

    logic req0, req1;
    logic pick1;

    assign req0 = m0_ren | m0_wen;
    assign req1 = m1_ren | m1_wen;

    // Winner of the arbitration held in IDLE (only meaningful when someone requests).
    always_comb begin
        pick1 = req1;
        if (req0 && req1) begin
            if (RR_MODE != 0) begin
                pick1 = ~last_gnt_q;
            end else begin
                pick1 = (wait_cnt_q == MaxWait);
            end
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d = pick1 ? StGnt1 : StGnt0;
                end
                if (RR_MODE == 0) begin
                    if (!req1 || pick1) begin
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q < MaxWait) begin
                        // req1 high but port 0 won
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            StGnt0: begin
                if (!req0) begin
                    state_d = StIdle;             // abort: last_gnt untouched
                end else if (!s_busy) begin
                    state_d    = StIdle;
                    last_gnt_d = 1'b0;
                end
            end
            StGnt1: begin
                if (!req1) begin
                    state_d = StIdle;
                end else if (!s_busy) begin
                    state_d    = StIdle;
                    last_gnt_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        grant     = 2'b00;
        abort_err = 1'b0;
        s_ren     = 1'b0;
        s_wen     = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        s_byte_en = '0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        m0_busy   = req0;
        m1_busy   = req1;
        unique case (state_q)
            StGnt0: begin
                grant     = 2'b01;
                s_ren     = m0_ren;
                s_wen     = m0_wen;
                s_addr    = m0_addr;
                s_wdata   = m0_wdata;
                s_byte_en = m0_byte_en;
                m0_rdata  = s_rdata;
                m0_busy   = s_busy;
                abort_err = ~req0;   // s_ren/s_wen are already 0 when req0 is low
            end
            StGnt1: begin
                grant     = 2'b10;
                s_ren     = m1_ren;
                s_wen     = m1_wen;
                s_addr    = m1_addr;
                s_wdata   = m1_wdata;
                s_byte_en = m1_byte_en;
                m1_rdata  = s_rdata;
                m1_busy   = s_busy;
                abort_err = ~req1;
            end
            default: ;
        endcase
    end

endmodule
